// File: rtl/hydration_pkg.sv
// Shared types and sizing helpers for the multi-bottle hydration tracker.
package hydration_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALERT   = 2'd2,
        ST_SNOOZE  = 2'd3
    } hyd_state_e;

    // Width that holds the sum of every channel's drop without overflow.
    function automatic int unsigned drop_sum_width(input int unsigned level_w,
                                                   input int unsigned channels);
        return level_w + $clog2(channels) + 1;
    endfunction

endpackage

// File: rtl/hydration_channel.sv
// One bottle sensor: primes on the first sample, then reports drops beyond the
// deadband combinationally and refills as a registered one-cycle pulse.
module hydration_channel #(
    parameter int unsigned LEVEL_W  = 4,
    parameter int unsigned DEADBAND = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] drop_c,
    output logic               refill
);

    logic [LEVEL_W-1:0] prev_q;
    logic               primed_q;
    logic               refill_q;
    logic               refill_d;
    logic [31:0]        prev_w;
    logic [31:0]        cur_w;

    // Compare in 32 bits so adding the deadband can never wrap.
    always_comb begin
        prev_w   = 32'(prev_q);
        cur_w    = 32'(level);
        drop_c   = '0;
        refill_d = 1'b0;
        if (sample_valid && primed_q) begin
            if (prev_w > cur_w + 32'(DEADBAND)) begin
                drop_c = prev_q - level;
            end
            refill_d = (cur_w > prev_w + 32'(DEADBAND));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            refill_q <= 1'b0;
        end else begin
            refill_q <= refill_d;
            if (sample_valid) begin
                prev_q   <= level;
                primed_q <= 1'b1;
            end
        end
    end

    assign refill = refill_q;

endmodule

// File: rtl/hydration_tracker.sv
// Multi-bottle drink/refill tracker with a saturating total and a reminder FSM
// that escalates after consecutive dry intervals.
module hydration_tracker
    import hydration_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned LEVEL_W    = 4,
    parameter int unsigned TOTAL_W    = 8,
    parameter int unsigned DEADBAND   = 1,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sample_valid,
    input  logic [CHANNELS*LEVEL_W-1:0]       level,
    input  logic                              interval_tick,
    input  logic                              clear_total,
    input  logic                              remind_ack,
    output logic [TOTAL_W-1:0]                total_drunk,
    output logic                              total_sat,
    output logic                              drank,
    output logic [CHANNELS-1:0]               refill,
    output logic [$clog2(MISS_LIMIT+1)-1:0]   missed,
    output logic                              remind
);

    localparam int unsigned SUM_W  = drop_sum_width(LEVEL_W, CHANNELS);
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int unsigned CMP_W  = ((SUM_W > TOTAL_W) ? SUM_W : TOTAL_W) + 1;
    localparam logic [CMP_W-1:0]  TOTAL_MAX = CMP_W'({TOTAL_W{1'b1}});
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

    logic [LEVEL_W-1:0] drop_c [CHANNELS];
    logic [SUM_W-1:0]   sum_c;
    logic               drink_c;
    logic               wet_c;
    logic [CMP_W-1:0]   headroom_c;
    logic [MISS_W-1:0]  missed_inc_c;
    logic               pend_expire_c;

    logic [TOTAL_W-1:0] total_q, total_d;
    logic               sat_q, sat_d;
    logic               drank_q, drank_d;
    logic [MISS_W-1:0]  missed_q, missed_d;
    hyd_state_e         state_q, state_d;
    logic               remind_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        hydration_channel #(
            .LEVEL_W  (LEVEL_W),
            .DEADBAND (DEADBAND)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .sample_valid (sample_valid),
            .level        (level[g*LEVEL_W +: LEVEL_W]),
            .drop_c       (drop_c[g]),
            .refill       (refill[g])
        );
    end

    // Sum of all channel drops for this sample.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum_c = sum_c + SUM_W'(drop_c[i]);
        end
    end

    assign drink_c = (sum_c != '0);
    assign wet_c   = drank_q | drink_c;

    // Saturating accumulator; clear discards a same-cycle add.
    always_comb begin
        headroom_c = TOTAL_MAX - CMP_W'(total_q);
        total_d    = total_q;
        sat_d      = sat_q;
        if (clear_total) begin
            total_d = '0;
            sat_d   = 1'b0;
        end else if (CMP_W'(sum_c) > headroom_c) begin
            total_d = '1;
            sat_d   = 1'b1;
        end else begin
            total_d = total_q + TOTAL_W'(sum_c);
        end
    end

    // Interval bookkeeping: a drink on the tick cycle belongs to the ending interval.
    always_comb begin
        missed_inc_c  = (missed_q >= MISS_MAX) ? missed_q : missed_q + MISS_W'(1);
        pend_expire_c = (32'(missed_q) + 32'd1 >= 32'(MISS_LIMIT));
        drank_d       = interval_tick ? 1'b0 : (drank_q | drink_c);
        missed_d      = missed_q;
        if (interval_tick) begin
            missed_d = wet_c ? '0 : missed_inc_c;
        end
        if (state_q == ST_ALERT && drink_c) begin
            missed_d = '0;
        end
    end

    // Reminder next state; a drink always beats an acknowledge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK: begin
                if (interval_tick && !wet_c) begin
                    state_d = (MISS_LIMIT == 1) ? ST_ALERT : ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (interval_tick) begin
                    if (wet_c) begin
                        state_d = ST_OK;
                    end else if (pend_expire_c) begin
                        state_d = ST_ALERT;
                    end
                end
            end
            ST_ALERT: begin
                if (drink_c) begin
                    state_d = ST_OK;
                end else if (remind_ack) begin
                    state_d = ST_SNOOZE;
                end
            end
            ST_SNOOZE: begin
                if (drink_c) begin
                    state_d = ST_OK;
                end else if (interval_tick) begin
                    state_d = wet_c ? ST_OK : ST_ALERT;
                end
            end
            default: state_d = ST_OK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q  <= '0;
            sat_q    <= 1'b0;
            drank_q  <= 1'b0;
            missed_q <= '0;
            state_q  <= ST_OK;
            remind_q <= 1'b0;
        end else begin
            total_q  <= total_d;
            sat_q    <= sat_d;
            drank_q  <= drank_d;
            missed_q <= missed_d;
            state_q  <= state_d;
            remind_q <= (state_d == ST_ALERT);
        end
    end

    assign total_drunk = total_q;
    assign total_sat   = sat_q;
    assign drank       = drank_q;
    assign missed      = missed_q;
    assign remind      = remind_q;

endmodule

// File: tb/tb_hydration_tracker.sv
// Directed bench for hydration_tracker: default build plus a narrow-total build
// for saturation.
module tb_hydration_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid, interval_tick, clear_total, remind_ack;
    logic [7:0] level;
    logic [7:0] total_drunk;
    logic       total_sat, drank, remind;
    logic [1:0] refill, missed;

    logic       sv_s, clr_s, tick_s, ack_s;
    logic [7:0] level_s;
    logic [3:0] total_s;
    logic       sat_s, drank_s, remind_s;
    logic [1:0] refill_s, missed_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hydration_tracker #(
        .CHANNELS(2), .LEVEL_W(4), .TOTAL_W(8), .DEADBAND(1), .MISS_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .level(level),
        .interval_tick(interval_tick), .clear_total(clear_total), .remind_ack(remind_ack),
        .total_drunk(total_drunk), .total_sat(total_sat), .drank(drank),
        .refill(refill), .missed(missed), .remind(remind)
    );

    hydration_tracker #(
        .CHANNELS(2), .LEVEL_W(4), .TOTAL_W(4), .DEADBAND(1), .MISS_LIMIT(2)
    ) dut_s (
        .clk(clk), .reset(reset), .sample_valid(sv_s), .level(level_s),
        .interval_tick(tick_s), .clear_total(clr_s), .remind_ack(ack_s),
        .total_drunk(total_s), .total_sat(sat_s), .drank(drank_s),
        .refill(refill_s), .missed(missed_s), .remind(remind_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of stimulus starting at a negedge; returns at the next negedge.
    task automatic step(input logic sv, input logic [3:0] l0, input logic [3:0] l1,
                        input logic tick, input logic clr, input logic ack);
        sample_valid  = sv;
        level         = {l1, l0};
        interval_tick = tick;
        clear_total   = clr;
        remind_ack    = ack;
        @(negedge clk);
        sample_valid  = 1'b0;
        interval_tick = 1'b0;
        clear_total   = 1'b0;
        remind_ack    = 1'b0;
    endtask

    task automatic step_s(input logic [3:0] l0, input logic [3:0] l1, input logic clr);
        sv_s    = 1'b1;
        level_s = {l1, l0};
        clr_s   = clr;
        @(negedge clk);
        sv_s  = 1'b0;
        clr_s = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0; interval_tick = 1'b0; clear_total = 1'b0; remind_ack = 1'b0;
        level = 8'h00;
        sv_s = 1'b0; clr_s = 1'b0; tick_s = 1'b0; ack_s = 1'b0; level_s = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_total",  32'(total_drunk), 32'd0);
        check("rst_sat",    32'(total_sat),   32'd0);
        check("rst_drank",  32'(drank),       32'd0);
        check("rst_refill", 32'(refill),      32'd0);
        check("rst_missed", 32'(missed),      32'd0);
        check("rst_remind", 32'(remind),      32'd0);
        reset = 1'b0;

        // Basic drink: 10->7 on ch0, ch1 steady at 5.
        step(1, 4'd10, 4'd5, 0, 0, 0);
        check("prime_total", 32'(total_drunk), 32'd0);
        check("prime_drank", 32'(drank),       32'd0);
        step(1, 4'd7, 4'd5, 0, 0, 0);
        check("drink_total", 32'(total_drunk), 32'd3);
        check("drink_drank", 32'(drank),       32'd1);
        step(0, 4'd7, 4'd5, 1, 0, 0);
        check("wet_tick_drank",  32'(drank),  32'd0);
        check("wet_tick_missed", 32'(missed), 32'd0);

        // Refill and deadband.
        step(1, 4'd10, 4'd5, 0, 0, 0);
        check("refill_pulse", 32'(refill),      32'd1);
        check("refill_total", 32'(total_drunk), 32'd3);
        check("refill_drank", 32'(drank),       32'd0);
        step(0, 4'd10, 4'd5, 0, 0, 0);
        check("refill_end",   32'(refill),      32'd0);
        step(1, 4'd9, 4'd5, 0, 0, 0);
        check("db_drop_total", 32'(total_drunk), 32'd3);
        check("db_drop_drank", 32'(drank),       32'd0);
        step(1, 4'd10, 4'd5, 0, 0, 0);
        check("db_rise_refill", 32'(refill),      32'd0);
        check("db_rise_total",  32'(total_drunk), 32'd3);
        step(1, 4'd4, 4'd5, 0, 0, 0);
        check("drop6_total", 32'(total_drunk), 32'd9);
        step(1, 4'd12, 4'd5, 0, 0, 0);
        check("big_refill",       32'(refill),      32'd1);
        check("big_refill_total", 32'(total_drunk), 32'd9);
        step(0, 4'd12, 4'd5, 0, 0, 0);
        check("big_refill_end",   32'(refill),      32'd0);
        step(0, 4'd12, 4'd5, 1, 0, 0);
        check("tick2_missed", 32'(missed), 32'd0);

        // Reminder escalation, snooze, and recovery by drinking.
        step(0, 4'd12, 4'd5, 1, 0, 0);
        check("dry1_missed", 32'(missed), 32'd1);
        check("dry1_remind", 32'(remind), 32'd0);
        step(0, 4'd12, 4'd5, 1, 0, 0);
        check("dry2_missed", 32'(missed), 32'd2);
        check("dry2_remind", 32'(remind), 32'd1);
        step(0, 4'd12, 4'd5, 0, 0, 1);
        check("snooze_remind", 32'(remind), 32'd0);
        step(0, 4'd12, 4'd5, 1, 0, 0);
        check("snooze_dry_remind", 32'(remind), 32'd1);
        check("snooze_dry_missed", 32'(missed), 32'd2);
        step(1, 4'd10, 4'd5, 0, 0, 0);
        check("alert_drink_remind", 32'(remind),      32'd0);
        check("alert_drink_missed", 32'(missed),      32'd0);
        check("alert_drink_total",  32'(total_drunk), 32'd11);

        // Drink coinciding with the tick while pending.
        step(0, 4'd10, 4'd5, 1, 0, 0);
        step(0, 4'd10, 4'd5, 1, 0, 0);
        check("pend_missed", 32'(missed), 32'd1);
        step(1, 4'd7, 4'd5, 1, 0, 0);
        check("tickdrink_missed", 32'(missed),      32'd0);
        check("tickdrink_drank",  32'(drank),       32'd0);
        check("tickdrink_total",  32'(total_drunk), 32'd14);
        check("tickdrink_remind", 32'(remind),      32'd0);

        // Drink and acknowledge together in ALERT: drink wins.
        step(0, 4'd7, 4'd5, 1, 0, 0);
        step(0, 4'd7, 4'd5, 1, 0, 0);
        check("alert2_remind", 32'(remind), 32'd1);
        step(1, 4'd5, 4'd5, 0, 0, 1);
        check("drink_ack_remind", 32'(remind),      32'd0);
        check("drink_ack_missed", 32'(missed),      32'd0);
        check("drink_ack_total",  32'(total_drunk), 32'd16);
        step(0, 4'd5, 4'd5, 1, 0, 0);
        check("post_ok_remind", 32'(remind), 32'd0);

        // Clear beats a same-cycle drop.
        step(1, 4'd2, 4'd5, 0, 1, 0);
        check("clear_total", 32'(total_drunk), 32'd0);
        check("clear_sat",   32'(total_sat),   32'd0);

        // Reset mid-run unprimes channels.
        pulse_reset();
        step(1, 4'd15, 4'd5, 0, 0, 0);
        step(1, 4'd15, 4'd5, 0, 0, 0);
        check("rst15_total", 32'(total_drunk), 32'd0);
        check("rst15_drank", 32'(drank),       32'd0);
        pulse_reset();
        step(1, 4'd8, 4'd5, 0, 0, 0);
        check("rst8_total", 32'(total_drunk), 32'd0);
        step(1, 4'd2, 4'd5, 0, 0, 0);
        check("rst82_total", 32'(total_drunk), 32'd6);

        // Saturation on the 4-bit total build.
        step_s(4'd15, 4'd15, 0);
        step_s(4'd6, 4'd6, 0);
        check("sat_total", 32'(total_s), 32'd15);
        check("sat_flag",  32'(sat_s),   32'd1);
        step_s(4'd15, 4'd15, 0);
        check("sat_sticky", 32'(sat_s),  32'd1);
        step_s(4'd12, 4'd15, 1);
        check("sat_clr_total", 32'(total_s), 32'd0);
        check("sat_clr_flag",  32'(sat_s),   32'd0);
        step_s(4'd10, 4'd15, 0);
        check("sat_add_total", 32'(total_s), 32'd2);
        check("sat_add_flag",  32'(sat_s),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
